// File: rtl/hmmm_control.sv
// hmmm_control: microcoded control unit of the 16-bit Hmmm bus CPU.
// One micro-step per clk: F0 (PC->MAR), F1 (MDR->IR, PC+1), then E0..Ek
// decoded from ir_data, then back to F0. All strobes are combinational
// from the phase/step registers and ir_data.
// Optional build macro: CONTROL_ILLEGAL_HALT_EN -- when defined, undefined
// encodings halt the machine instead of executing as a one-step nop.
// There are no handshakes here: every output is a plain level strobe valid
// for the whole cycle it is asserted in; dbg_phase/dbg_step expose the FSM.
module hmmm_control (
  input  logic        clk,
  input  logic        rst,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        pc_out,
  output logic        pc_jump,
  output logic        pc_increment,
  output logic        tmp0_in,
  output logic        tmp1_in,
  output logic        tmp0_out,
  output logic        tmp1_out,
  output logic        alu_out,
  output logic [2:0]  alu_op,
  output logic        flags_in,
  input  logic [2:0]  flags_data,
  output logic [3:0]  reg_sel,
  output logic        reg_in,
  output logic        reg_out,
  output logic        ir_in,
  output logic        ir_out,
  input  logic [15:0] ir_data,
  output logic        in_out,
  output logic        out_in,
  output logic        halt,
  inout  wire  [15:0] bus,
  output logic [1:0]  dbg_phase,
  output logic [2:0]  dbg_step
);

  typedef enum logic [1:0] {
    PH_F0   = 2'd0,
    PH_F1   = 2'd1,
    PH_EXEC = 2'd2,
    PH_HALT = 2'd3
  } phase_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

`ifdef CONTROL_ILLEGAL_HALT_EN
  localparam bit HALT_ON_ILLEGAL = 1'b1;
`else
  localparam bit HALT_ON_ILLEGAL = 1'b0;
`endif

  phase_t      phase_q, phase_d;
  logic [2:0]  step_q, step_d;

  logic [3:0]  opcode, fx, fy, fz;
  logic [7:0]  fn;
  logic [15:0] sext_n;
  logic        is_illegal;
  logic        is_halt;
  logic [2:0]  last_step;
  logic        take_branch;
  logic        bus_en;
  logic [15:0] bus_val;

  assign opcode = ir_data[15:12];
  assign fx     = ir_data[11:8];
  assign fy     = ir_data[7:4];
  assign fz     = ir_data[3:0];
  assign fn     = ir_data[7:0];
  assign sext_n = {{8{fn[7]}}, fn};

  // TMP registers never drive the bus from this control unit.
  assign tmp0_out = 1'b0;
  assign tmp1_out = 1'b0;

  assign bus       = bus_en ? bus_val : 16'hzzzz;
  assign dbg_phase = phase_q;
  assign dbg_step  = step_q;

  // Classify the encoding and find the index of its final execute step.
  always_comb begin
    is_illegal = 1'b0;
    last_step  = 3'd0;
    case (opcode)
      4'h0: is_illegal = (fn > 8'h03);
      4'h2, 4'h3: last_step = 3'd1;
      4'h4: begin
        case (fz)
          4'd0, 4'd1: last_step = 3'd1;
          4'd2, 4'd3: last_step = 3'd4;
          default:    is_illegal = 1'b1;
        endcase
      end
      4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: last_step = 3'd2;
      4'hB: last_step = (fx == 4'd0) ? 3'd0 : 3'd1;
      4'hC, 4'hD, 4'hE, 4'hF: last_step = 3'd3;
      default: last_step = 3'd0;
    endcase
  end

  assign is_halt = ((opcode == 4'h0) && (fn == 8'h00)) || (HALT_ON_ILLEGAL && is_illegal);

  // Branch condition for jeqzn/jnezn/jgtzn/jltzn from {neg,zero,pos}.
  always_comb begin
    take_branch = 1'b0;
    case (opcode)
      4'hC:    take_branch = flags_data[1];
      4'hD:    take_branch = ~flags_data[1];
      4'hE:    take_branch = flags_data[0];
      4'hF:    take_branch = flags_data[2];
      default: take_branch = 1'b0;
    endcase
  end

  // Phase/step register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= PH_F0;
      step_q  <= 3'd0;
    end else begin
      phase_q <= phase_d;
      step_q  <= step_d;
    end
  end

  // Next phase/step: fetch twice, execute to the last step, then refetch or halt.
  always_comb begin
    phase_d = phase_q;
    step_d  = step_q;
    case (phase_q)
      PH_F0: begin
        phase_d = PH_F1;
        step_d  = 3'd0;
      end
      PH_F1: begin
        phase_d = PH_EXEC;
        step_d  = 3'd0;
      end
      PH_EXEC: begin
        if (step_q >= last_step) begin
          phase_d = is_halt ? PH_HALT : PH_F0;
          step_d  = 3'd0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      PH_HALT: begin
        phase_d = PH_HALT;
        step_d  = 3'd0;
      end
      default: begin
        phase_d = PH_F0;
        step_d  = 3'd0;
      end
    endcase
  end

  // Micro-step strobes; at most one bus driver is selected per cycle.
  always_comb begin
    mar_in       = 1'b0;
    mdr_in       = 1'b0;
    mdr_out      = 1'b0;
    pc_out       = 1'b0;
    pc_jump      = 1'b0;
    pc_increment = 1'b0;
    tmp0_in      = 1'b0;
    tmp1_in      = 1'b0;
    alu_out      = 1'b0;
    alu_op       = ALU_ADD;
    flags_in     = 1'b0;
    reg_sel      = 4'd0;
    reg_in       = 1'b0;
    reg_out      = 1'b0;
    ir_in        = 1'b0;
    ir_out       = 1'b0;
    in_out       = 1'b0;
    out_in       = 1'b0;
    halt         = 1'b0;
    bus_en       = 1'b0;
    bus_val      = 16'h0000;
    case (phase_q)
      PH_F0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
      end
      PH_F1: begin
        mdr_out      = 1'b1;
        ir_in        = 1'b1;
        pc_increment = 1'b1;
      end
      PH_HALT: halt = 1'b1;
      PH_EXEC: begin
        if (is_halt) begin
          halt = 1'b1;
        end else begin
          case (opcode)
            4'h0: begin
              case (fn)
                8'h01: begin in_out = 1'b1; reg_in = 1'b1; reg_sel = fx; end
                8'h02: begin reg_out = 1'b1; out_in = 1'b1; reg_sel = fx; end
                8'h03: begin reg_out = 1'b1; pc_jump = 1'b1; reg_sel = fx; end
                default: ;
              endcase
            end
            4'h1: begin
              bus_en  = 1'b1;
              bus_val = sext_n;
              reg_in  = 1'b1;
              reg_sel = fx;
            end
            4'h2: begin
              if (step_q == 3'd0) begin ir_out = 1'b1; mar_in = 1'b1; end
              else begin mdr_out = 1'b1; reg_in = 1'b1; reg_sel = fx; end
            end
            4'h3: begin
              if (step_q == 3'd0) begin ir_out = 1'b1; mar_in = 1'b1; end
              else begin reg_out = 1'b1; mdr_in = 1'b1; reg_sel = fx; end
            end
            4'h4: begin
              case (fz)
                4'd0: begin
                  if (step_q == 3'd0) begin reg_out = 1'b1; mar_in = 1'b1; reg_sel = fy; end
                  else begin mdr_out = 1'b1; reg_in = 1'b1; reg_sel = fx; end
                end
                4'd1: begin
                  if (step_q == 3'd0) begin reg_out = 1'b1; mar_in = 1'b1; reg_sel = fy; end
                  else begin reg_out = 1'b1; mdr_in = 1'b1; reg_sel = fx; end
                end
                4'd2: begin
                  case (step_q)
                    3'd0: begin reg_out = 1'b1; tmp0_in = 1'b1; reg_sel = fy; end
                    3'd1: begin bus_en = 1'b1; bus_val = 16'h0001; tmp1_in = 1'b1; end
                    3'd2: begin alu_out = 1'b1; alu_op = ALU_SUB; reg_in = 1'b1; reg_sel = fy; end
                    3'd3: begin reg_out = 1'b1; mar_in = 1'b1; reg_sel = fy; end
                    default: begin mdr_out = 1'b1; reg_in = 1'b1; reg_sel = fx; end
                  endcase
                end
                4'd3: begin
                  case (step_q)
                    3'd0: begin reg_out = 1'b1; mar_in = 1'b1; reg_sel = fy; end
                    3'd1: begin reg_out = 1'b1; mdr_in = 1'b1; reg_sel = fx; end
                    3'd2: begin reg_out = 1'b1; tmp0_in = 1'b1; reg_sel = fy; end
                    3'd3: begin bus_en = 1'b1; bus_val = 16'h0001; tmp1_in = 1'b1; end
                    default: begin alu_out = 1'b1; alu_op = ALU_ADD; reg_in = 1'b1; reg_sel = fy; end
                  endcase
                end
                default: ;
              endcase
            end
            4'h5: begin
              case (step_q)
                3'd0: begin reg_out = 1'b1; tmp0_in = 1'b1; reg_sel = fx; end
                3'd1: begin bus_en = 1'b1; bus_val = sext_n; tmp1_in = 1'b1; end
                default: begin
                  alu_out  = 1'b1;
                  alu_op   = ALU_ADD;
                  flags_in = 1'b1;
                  reg_in   = 1'b1;
                  reg_sel  = fx;
                end
              endcase
            end
            4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
              case (step_q)
                3'd0: begin reg_out = 1'b1; tmp0_in = 1'b1; reg_sel = fy; end
                3'd1: begin reg_out = 1'b1; tmp1_in = 1'b1; reg_sel = fz; end
                default: begin
                  alu_out  = 1'b1;
                  alu_op   = 3'(opcode - 4'd6);
                  flags_in = 1'b1;
                  reg_in   = 1'b1;
                  reg_sel  = fx;
                end
              endcase
            end
            4'hB: begin
              if (fx == 4'd0 || step_q != 3'd0) begin
                ir_out  = 1'b1;
                pc_jump = 1'b1;
              end else begin
                pc_out  = 1'b1;
                reg_in  = 1'b1;
                reg_sel = fx;
              end
            end
            default: begin
              case (step_q)
                3'd0: begin reg_out = 1'b1; tmp0_in = 1'b1; reg_sel = fx; end
                3'd1: begin bus_en = 1'b1; bus_val = 16'h0000; tmp1_in = 1'b1; end
                3'd2: begin alu_op = ALU_ADD; flags_in = 1'b1; end
                default: begin
                  if (take_branch) begin
                    ir_out  = 1'b1;
                    pc_jump = 1'b1;
                  end
                end
              endcase
            end
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hmmm_control.sv
// tb_hmmm_control: randomized instruction stream against a per-instruction
// micro-step model; a negedge monitor checks every cycle's strobes.
module tb_hmmm_control;

  localparam int W = 43;
  // Expected-vector layout: [42] bus driven, [41:31] single strobes,
  // [30:28] alu_op, [27] flags_in, [26:23] reg_sel, [22:16] strobes, [15:0] bus.
  localparam logic [W-1:0] M_BUS    = 43'h1 << 42;
  localparam logic [W-1:0] M_MAR_IN = 43'h1 << 41;
  localparam logic [W-1:0] M_MDR_IN = 43'h1 << 40;
  localparam logic [W-1:0] M_MDR_OUT = 43'h1 << 39;
  localparam logic [W-1:0] M_PC_OUT = 43'h1 << 38;
  localparam logic [W-1:0] M_PC_JMP = 43'h1 << 37;
  localparam logic [W-1:0] M_PC_INC = 43'h1 << 36;
  localparam logic [W-1:0] M_T0_IN  = 43'h1 << 35;
  localparam logic [W-1:0] M_T1_IN  = 43'h1 << 34;
  localparam logic [W-1:0] M_ALU_OUT = 43'h1 << 31;
  localparam logic [W-1:0] M_FLAGS  = 43'h1 << 27;
  localparam logic [W-1:0] M_REG_IN = 43'h1 << 22;
  localparam logic [W-1:0] M_REG_OUT = 43'h1 << 21;
  localparam logic [W-1:0] M_IR_IN  = 43'h1 << 20;
  localparam logic [W-1:0] M_IR_OUT = 43'h1 << 19;
  localparam logic [W-1:0] M_IN_OUT = 43'h1 << 18;
  localparam logic [W-1:0] M_OUT_IN = 43'h1 << 17;
  localparam logic [W-1:0] M_HALT   = 43'h1 << 16;

`ifdef CONTROL_ILLEGAL_HALT_EN
  localparam bit ILL_HALT = 1'b1;
`else
  localparam bit ILL_HALT = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir_data;
  logic [2:0]  flags_data;
  logic mar_in, mdr_in, mdr_out, pc_out, pc_jump, pc_increment;
  logic tmp0_in, tmp1_in, tmp0_out, tmp1_out, alu_out, flags_in;
  logic [2:0] alu_op;
  logic [3:0] reg_sel;
  logic reg_in, reg_out, ir_in, ir_out, in_out, out_in, halt;
  wire  [15:0] bus;
  logic [1:0] dbg_phase;
  logic [2:0] dbg_step;

  always #5 clk = ~clk;

  hmmm_control dut (
    .clk(clk), .rst(rst),
    .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .pc_out(pc_out), .pc_jump(pc_jump), .pc_increment(pc_increment),
    .tmp0_in(tmp0_in), .tmp1_in(tmp1_in), .tmp0_out(tmp0_out), .tmp1_out(tmp1_out),
    .alu_out(alu_out), .alu_op(alu_op), .flags_in(flags_in), .flags_data(flags_data),
    .reg_sel(reg_sel), .reg_in(reg_in), .reg_out(reg_out),
    .ir_in(ir_in), .ir_out(ir_out), .ir_data(ir_data),
    .in_out(in_out), .out_in(out_in), .halt(halt), .bus(bus),
    .dbg_phase(dbg_phase), .dbg_step(dbg_step)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] seq[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] e_v, a_v;

  function automatic logic [W-1:0] st(input logic [W-1:0] m, input logic [3:0] rs,
                                      input logic [2:0] op, input logic [15:0] bv);
    logic [W-1:0] v;
    v = m;
    v[26:23] = rs;
    v[30:28] = op;
    if (m[42]) v[15:0] = bv;
    return v;
  endfunction

  function automatic logic [W-1:0] pack_act(input bit drv);
    logic [W-1:0] v;
    v = '0;
    v[41] = mar_in;   v[40] = mdr_in;   v[39] = mdr_out; v[38] = pc_out;
    v[37] = pc_jump;  v[36] = pc_increment; v[35] = tmp0_in; v[34] = tmp1_in;
    v[33] = tmp0_out; v[32] = tmp1_out; v[31] = alu_out;
    v[30:28] = alu_op; v[27] = flags_in; v[26:23] = reg_sel;
    v[22] = reg_in;   v[21] = reg_out;  v[20] = ir_in;   v[19] = ir_out;
    v[18] = in_out;   v[17] = out_in;   v[16] = halt;
    v[15:0] = drv ? bus : 16'h0000;
    return v;
  endfunction

  task automatic p(input logic [W-1:0] m, input logic [3:0] rs, input logic [2:0] op,
                   input logic [15:0] bv);
    seq.push_back(st(m, rs, op, bv));
  endtask

  // ---------------- reference model ----------------
  // Builds the full cycle-by-cycle strobe list for one instruction.
  task automatic model(input logic [15:0] ir, input logic [2:0] fl, output bit halts);
    logic [3:0] op, x, y, z;
    logic [15:0] sx;
    bit taken;
    op = ir[15:12]; x = ir[11:8]; y = ir[7:4]; z = ir[3:0];
    sx = {{8{ir[7]}}, ir[7:0]};
    halts = 1'b0;
    seq.delete();
    p(M_PC_OUT | M_MAR_IN, 0, 0, 0);
    p(M_MDR_OUT | M_IR_IN | M_PC_INC, 0, 0, 0);
    if (op == 0 && ir[7:0] == 8'h00) begin
      p(M_HALT, 0, 0, 0); halts = 1'b1;
    end else if ((op == 0 && ir[7:0] > 8'h03) || (op == 4 && z > 3)) begin
      if (ILL_HALT) begin p(M_HALT, 0, 0, 0); halts = 1'b1; end
      else p('0, 0, 0, 0);
    end else if (op == 0) begin
      if (ir[7:0] == 8'h01) p(M_IN_OUT | M_REG_IN, x, 0, 0);
      else if (ir[7:0] == 8'h02) p(M_REG_OUT | M_OUT_IN, x, 0, 0);
      else p(M_REG_OUT | M_PC_JMP, x, 0, 0);
    end else if (op == 1) begin
      p(M_BUS | M_REG_IN, x, 0, sx);
    end else if (op == 2) begin
      p(M_IR_OUT | M_MAR_IN, 0, 0, 0); p(M_MDR_OUT | M_REG_IN, x, 0, 0);
    end else if (op == 3) begin
      p(M_IR_OUT | M_MAR_IN, 0, 0, 0); p(M_REG_OUT | M_MDR_IN, x, 0, 0);
    end else if (op == 4 && z == 0) begin
      p(M_REG_OUT | M_MAR_IN, y, 0, 0); p(M_MDR_OUT | M_REG_IN, x, 0, 0);
    end else if (op == 4 && z == 1) begin
      p(M_REG_OUT | M_MAR_IN, y, 0, 0); p(M_REG_OUT | M_MDR_IN, x, 0, 0);
    end else if (op == 4 && z == 2) begin
      p(M_REG_OUT | M_T0_IN, y, 0, 0);
      p(M_BUS | M_T1_IN, 0, 0, 16'h0001);
      p(M_ALU_OUT | M_REG_IN, y, 3'd1, 0);
      p(M_REG_OUT | M_MAR_IN, y, 0, 0);
      p(M_MDR_OUT | M_REG_IN, x, 0, 0);
    end else if (op == 4) begin
      p(M_REG_OUT | M_MAR_IN, y, 0, 0);
      p(M_REG_OUT | M_MDR_IN, x, 0, 0);
      p(M_REG_OUT | M_T0_IN, y, 0, 0);
      p(M_BUS | M_T1_IN, 0, 0, 16'h0001);
      p(M_ALU_OUT | M_REG_IN, y, 3'd0, 0);
    end else if (op == 5) begin
      p(M_REG_OUT | M_T0_IN, x, 0, 0);
      p(M_BUS | M_T1_IN, 0, 0, sx);
      p(M_ALU_OUT | M_FLAGS | M_REG_IN, x, 3'd0, 0);
    end else if (op >= 6 && op <= 10) begin
      p(M_REG_OUT | M_T0_IN, y, 0, 0);
      p(M_REG_OUT | M_T1_IN, z, 0, 0);
      p(M_ALU_OUT | M_FLAGS | M_REG_IN, x, 3'(op - 6), 0);
    end else if (op == 11) begin
      if (x != 0) p(M_PC_OUT | M_REG_IN, x, 0, 0);
      p(M_IR_OUT | M_PC_JMP, 0, 0, 0);
    end else begin
      // fl = {neg, zero, pos}
      case (op)
        4'd12:   taken = fl[1];
        4'd13:   taken = !fl[1];
        4'd14:   taken = fl[0];
        default: taken = fl[2];
      endcase
      p(M_REG_OUT | M_T0_IN, x, 0, 0);
      p(M_BUS | M_T1_IN, 0, 0, 16'h0000);
      p(M_FLAGS, 0, 0, 0);
      p(taken ? (M_IR_OUT | M_PC_JMP) : '0, 0, 0, 0);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after the posedge that put the DUT into F0.
  task automatic run_instr(input logic [15:0] ir, input logic [2:0] fl, input int abort_at);
    bit halts;
    int len;
    ir_data = ir;
    flags_data = fl;
    model(ir, fl, halts);
    len = seq.size();
    if (!halts && abort_at >= 0 && abort_at < len) begin
      for (int i = 0; i <= abort_at; i++) exp_q.push_back(seq[i]);
      repeat (abort_at) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
    end else begin
      for (int i = 0; i < len; i++) exp_q.push_back(seq[i]);
      repeat (len) @(posedge clk);
      #1;
      if (halts) begin
        repeat ($urandom_range(1, 4)) begin
          ir_data = 16'($urandom);
          exp_q.push_back(st(M_HALT, 0, 0, 0));
          @(posedge clk); #1;
        end
        rst = 1'b0;
        exp_q.push_back(st(M_HALT, 0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b1;
      end
    end
  endtask

  // ---------------- monitor ----------------
  // Every cycle is an output: pop one expected step and compare.
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL step_underflow t=%0t: DUT cycle with no expected entry", $time);
      end else begin
        e_v = exp_q.pop_front();
        a_v = pack_act(e_v[42]);
        if (a_v[41:0] !== e_v[41:0]) begin
          n_bad++;
          $display("FAIL step ir=%h t=%0t: got %h expected %h", ir_data, $time,
                   a_v[41:0], e_v[41:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] r_ir;
    int r_sel;
    int r_abort;
    rst = 1'b0;
    ir_data = 16'h0000;
    flags_data = 3'b000;
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;

    repeat (4) run_instr(16'h112A, 3'b000, -1);
    run_instr(16'h112A, 3'b000, 1);
    run_instr(16'h11FF, 3'b000, -1);
    run_instr(16'h6123, 3'b000, -1);
    run_instr(16'hC310, 3'b010, -1);
    run_instr(16'hC310, 3'b001, -1);
    run_instr(16'h0000, 3'b000, -1);
    run_instr(16'h00FF, 3'b000, -1);
    run_instr(16'h4152, 3'b000, -1);
    run_instr(16'h4153, 3'b000, -1);
    run_instr(16'hB500, 3'b000, -1);
    run_instr(16'h4153, 3'b000, 3);

    for (int k = 0; k < 300; k++) begin
      r_ir = 16'($urandom);
      if (r_ir[15:12] == 4'h0) begin
        r_sel = $urandom_range(0, 9);
        if (r_sel < 4) r_ir[7:0] = 8'(r_sel);
      end
      r_abort = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1;
      run_instr(r_ir, 3'($urandom_range(0, 7)), r_abort);
    end

    mon_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d expected steps never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
